// File: rtl/ds_rr_arbiter.sv
// Packet-aware round-robin arbiter for DataStream inputs.
// A packet keeps its grant until its eop beat; the output has one register stage.
module ds_rr_arbiter #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned PORTS = 4,
    localparam int unsigned SELW  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                         reset,
    input  logic                         clk,
    input  logic [PORTS-1:0][WIDTH-1:0]  i_dat,
    input  logic [PORTS-1:0]             i_val,
    input  logic [PORTS-1:0]             i_eop,
    output logic [PORTS-1:0]             i_rdy,
    output logic [WIDTH-1:0]             o_dat,
    output logic                         o_val,
    output logic                         o_eop,
    output logic [SELW-1:0]              o_sel,
    input  logic                         o_rdy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [SELW-1:0]  gnt_q, gnt_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] o_dat_q, o_dat_d;
    logic             o_val_q, o_val_d;
    logic             o_eop_q, o_eop_d;
    logic [SELW-1:0]  o_sel_q, o_sel_d;

    logic             found_c;
    logic [SELW-1:0]  sel_c;
    logic [SELW-1:0]  cur_c;
    logic [SELW-1:0]  nxt_c;
    logic             cur_val_c;
    logic             stage_rdy_c;
    logic             xfer_c;

    // First valid port, searching upward from ptr with wrap-around
    always_comb begin
        int unsigned idx;
        found_c = 1'b0;
        sel_c   = '0;
        idx     = 0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= PORTS) begin
                idx = idx - PORTS;
            end
            if (!found_c && i_val[SELW'(idx)]) begin
                found_c = 1'b1;
                sel_c   = SELW'(idx);
            end
        end
    end

    // Grant, ready generation, packet tracking and output stage load
    always_comb begin
        mode_d  = mode_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        o_dat_d = o_dat_q;
        o_val_d = o_val_q;
        o_eop_d = o_eop_q;
        o_sel_d = o_sel_q;
        i_rdy   = '0;

        stage_rdy_c = o_rdy | ~o_val_q;
        cur_c       = (mode_q == BUSY) ? gnt_q : sel_c;
        cur_val_c   = (mode_q == BUSY) ? i_val[gnt_q] : found_c;
        nxt_c       = (32'(cur_c) == PORTS - 1) ? '0 : cur_c + SELW'(1);

        // In BUSY the grant holds even through bubbles, so ready is offered regardless of valid
        if (reset && ((mode_q == BUSY) || found_c)) begin
            i_rdy[cur_c] = stage_rdy_c;
        end
        xfer_c = reset & cur_val_c & stage_rdy_c;

        if (stage_rdy_c) begin
            o_val_d = xfer_c;
            if (xfer_c) begin
                o_dat_d = i_dat[cur_c];
                o_eop_d = i_eop[cur_c];
                o_sel_d = cur_c;
            end
        end

        if (xfer_c) begin
            if (i_eop[cur_c]) begin
                mode_d = IDLE;
                ptr_d  = nxt_c;
            end else begin
                mode_d = BUSY;
                gnt_d  = cur_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q  <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            o_dat_q <= '0;
            o_val_q <= 1'b0;
            o_eop_q <= 1'b0;
            o_sel_q <= '0;
        end else begin
            mode_q  <= mode_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            o_dat_q <= o_dat_d;
            o_val_q <= o_val_d;
            o_eop_q <= o_eop_d;
            o_sel_q <= o_sel_d;
        end
    end

    assign o_dat = o_dat_q;
    assign o_val = o_val_q;
    assign o_eop = o_eop_q;
    assign o_sel = o_sel_q;

endmodule
